mmio_bus_ctrl: RTL and testbench
================================

Name: mmio_bus_ctrl

Overview:
- Memory-mapped bus controller directly downstream of the processor: consumes its registered ADDR/DOUT/W outputs and returns read data on DIN.
- Decodes the 16-bit address space into a RAM region, LED, HEX and switch ports, and a prescaled down-counting timer with a sticky expiry flag.
- All peripheral state lives here; RAM storage is an external synchronous block driven through the mem_* ports.

Parameters:
- LED_W, 10, width of LEDR output register
- SW_W, 10, width of SW input port
- PRESCALE, 50000, clock cycles per timer tick (>=1; 1 ms at 50 MHz)

Ports:
- Clock  in  1  system clock, all state on rising edge
- Resetn  in  1  asynchronous active-low reset
- ADDR  in  16  address from processor (registered upstream)
- DOUT  in  16  write data from processor
- W  in  1  write strobe, aligned with ADDR/DOUT
- DIN  out  16  read data to processor (combinational from ADDR and state)
- mem_addr  out  12  RAM address = ADDR[11:0]
- mem_wdata  out  16  RAM write data = DOUT
- mem_we  out  1  RAM write enable
- mem_q  in  16  RAM read data
- SW  in  SW_W  asynchronous slide switches
- LEDR  out  LED_W  LED register
- HEX  out  28  four 7-bit display digits, HEX[6:0] = digit 0
- T_EXP  out  1  timer expired flag (level)

Behaviour:
- Region select on ADDR[15:12]: 0=RAM, 1=LEDR, 2=HEX, 3=SW, 4=timer; 5..F unmapped.
- Writes commit on the rising edge with W=1, using ADDR/DOUT of that cycle; single-cycle, no stall.
- mem_we = W & (region 0); combinational. Writes to SW or unmapped regions are ignored.
- LEDR <= DOUT[LED_W-1:0] on write to region 1. HEX data register (16 b) <= DOUT on write to region 2.
- SW passes through a 2-flop synchronizer; reads return the second-stage value zero-extended. Latency from SW change to readable value: 2 clocks.
- Timer registers, selected by ADDR[1:0] within region 4:
  - 0 TLOAD (R/W): a write also sets TCOUNT <= DOUT and clears the prescaler.
  - 1 TCTRL (R/W): bit0 EN, bit1 AUTO; other bits read 0.
  - 2 TSTAT: bit0 EXP; writing 1 to bit0 clears it (W1C); writing 0 has no effect.
  - 3 TCOUNT (RO): writes are ignored.
- Prescaler: counts 0..PRESCALE-1 while EN=1 and emits a tick when it wraps to 0. Held at 0 while EN=0.
- On each tick:
  - TCOUNT>1: decrement.
  - TCOUNT==1: TCOUNT <= 0 and EXP <= 1.
  - TCOUNT==0 and AUTO=1: TCOUNT <= TLOAD.
  - TCOUNT==0 and AUTO=0: hold.
- Simultaneous events:
  - Tick-set of EXP in the same cycle as a W1C: the set wins.
  - TLOAD write in the same cycle as a tick: the write wins, and the prescaler restarts.
- T_EXP = EXP.
- DIN mux:
  - Region 0: mem_q.
  - Regions 1..4: the selected register, zero-extended.
  - Unmapped: 16'h0000.
- Reset (asynchronous, Resetn=0):
  - LEDR=0, HEX reg=0, sync flops=0.
  - TLOAD=0, TCTRL=0, TCOUNT=0, EXP=0, prescaler=0.
  - DIN then reflects decode of the current ADDR.
- Reset mid-count aborts the count. No tick is produced in the cycle Resetn deasserts.

Optional Feature:
- Macro HEX_DECODE_EN.
- Defined: each nibble of the HEX register drives a hex-to-7-segment decoder. Outputs are active-low (segment on = 0; digit 0 all on except g = 7'b1000000).
- Undefined: HEX[15:0] = HEX register raw and HEX[27:16] = all ones. No decoder logic is present.
- Register read-back is identical in both builds.

Test Plan:
- Reset, then hold Resetn=0 mid-run -> LEDR=0, T_EXP=0. DIN at ADDR=16'h4003 reads 0; at 16'h5000 reads 0.
- Write ADDR=16'h1000 DOUT=16'hFFFF W=1 -> LEDR=10'h3FF next edge. Write ADDR=16'h0123 -> mem_we=1, mem_addr=12'h123. ADDR=16'h0005 with mem_q=16'hBEEF -> DIN=16'hBEEF.
- SW changes 0 -> 10'h2A5 -> DIN at 16'h3000 stays 0 for 1 edge, then reads 16'h02A5 after the 2nd edge.
- PRESCALE=4: write TLOAD=3, TCTRL=1 -> TCOUNT 3,2,1,0 at 4-cycle spacing. EXP/T_EXP set with TCOUNT reaching 0. TCOUNT holds 0.
- TCTRL=3 (AUTO), TLOAD=2 -> TCOUNT sequence 2,1,0,2,1,0. W1C to 16'h4002 on the exact cycle of expiry -> EXP remains 1. W1C one cycle later -> EXP=0.
- HEX_DECODE_EN defined: write 16'h0A80 to 16'h2000 -> HEX[6:0]=7'b1000000, HEX[13:7]=7'b0000000, HEX[20:14]=7'b0001000. Undefined: HEX=28'hFFF0A80.

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: memory-mapped bus controller (RAM, LEDR, HEX, SW, prescaled timer)
// Ports:
//   Clock, Resetn          clock, asynchronous active-low reset
//   ADDR, DOUT, W          registered processor address, write data, write strobe
//   DIN                    combinational read data back to the processor
//   mem_addr, mem_wdata,
//   mem_we, mem_q          external synchronous RAM interface (region 0)
//   SW                     asynchronous slide switches, 2-flop synchronized
//   LEDR                   LED register (region 1)
//   HEX                    four 7-bit digits, HEX[6:0] = digit 0 (region 2)
//   T_EXP                  sticky timer expiry flag (region 4)
// Build option: define HEX_DECODE_EN to drive HEX through active-low 7-segment
// decoders; otherwise HEX = {12'hFFF, raw HEX register}.
module mmio_bus_ctrl #(
    parameter int LED_W    = 10,
    parameter int SW_W     = 10,
    parameter int PRESCALE = 50000
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DOUT,
    input  logic             W,
    output logic [15:0]      DIN,
    output logic [11:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_we,
    input  logic [15:0]      mem_q,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LEDR,
    output logic [27:0]      HEX,
    output logic             T_EXP
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [3:0]      region;
    logic [15:0]     hex_reg;
    logic [15:0]     tload;
    logic [15:0]     tcount;
    logic [15:0]     timer_rd;
    logic [1:0]      tctrl;
    logic            exp_flag;
    logic [PW-1:0]   presc;
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic            wr_tim;
    logic            wr_tload;
    logic            tick;

    assign region    = ADDR[15:12];
    assign mem_addr  = ADDR[11:0];
    assign mem_wdata = DOUT;
    assign mem_we    = W && region == 4'h0;
    assign wr_tim    = W && region == 4'h4;
    assign wr_tload  = wr_tim && ADDR[1:0] == 2'd0;
    // A TLOAD write restarts the prescaler, so it swallows a coincident tick.
    assign tick      = tctrl[0] && presc == PW'(PRESCALE - 1) && !wr_tload;
    assign T_EXP     = exp_flag;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            LEDR     <= '0;
            hex_reg  <= '0;
            tload    <= '0;
            tctrl    <= '0;
            tcount   <= '0;
            exp_flag <= 1'b0;
            presc    <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            if (W && region == 4'h1) LEDR <= DOUT[LED_W-1:0];
            if (W && region == 4'h2) hex_reg <= DOUT;
            if (wr_tload) tload <= DOUT;
            if (wr_tim && ADDR[1:0] == 2'd1) tctrl <= DOUT[1:0];
            presc <= (wr_tload || !tctrl[0] || tick) ? '0 : presc + 1'b1;
            if (wr_tload)
                tcount <= DOUT;
            else if (tick && tcount != 16'd0)
                tcount <= tcount - 16'd1;
            else if (tick && tctrl[1])
                tcount <= tload;
            // Expiry set takes priority over a same-cycle W1C.
            if (tick && tcount == 16'd1)
                exp_flag <= 1'b1;
            else if (wr_tim && ADDR[1:0] == 2'd2 && DOUT[0])
                exp_flag <= 1'b0;
        end
    end

    always_comb begin
        timer_rd = ADDR[1:0] == 2'd0 ? tload :
                   ADDR[1:0] == 2'd1 ? {14'b0, tctrl} :
                   ADDR[1:0] == 2'd2 ? {15'b0, exp_flag} : tcount;
        DIN      = region == 4'h0 ? mem_q :
                   region == 4'h1 ? 16'(LEDR) :
                   region == 4'h2 ? hex_reg :
                   region == 4'h3 ? 16'(sw_s2) :
                   region == 4'h4 ? timer_rd : 16'h0000;
    end

`ifdef HEX_DECODE_EN
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign HEX = {seg7(hex_reg[15:12]), seg7(hex_reg[11:8]), seg7(hex_reg[7:4]), seg7(hex_reg[3:0])};
`else
    assign HEX = {12'hFFF, hex_reg};
`endif
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: scoreboard bench for mmio_bus_ctrl (PRESCALE=4)
module tb_mmio_bus_ctrl;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] DOUT = '0;
    logic        W = 1'b0;
    logic [15:0] mem_q = '0;
    logic [9:0]  SW = '0;
    logic [15:0] DIN;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [9:0]  LEDR;
    logic [27:0] HEX;
    logic        T_EXP;

    mmio_bus_ctrl #(.LED_W(10), .SW_W(10), .PRESCALE(4)) dut (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .DIN(DIN), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_q(mem_q), .SW(SW), .LEDR(LEDR), .HEX(HEX), .T_EXP(T_EXP)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          due;
        int          sel;
        logic [27:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [27:0] actual(input int sel);
        case (sel)
            0: return {12'b0, DIN};
            1: return {18'b0, LEDR};
            2: return {27'b0, T_EXP};
            3: return {27'b0, mem_we};
            4: return {16'b0, mem_addr};
            default: return HEX;
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    always @(negedge Clock) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [27:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (e.due != cyc || a !== e.val) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h (cycle %0d, due %0d)", e.name, a, e.val, cyc, e.due);
            end
        end
    end

    task automatic chk(input int sel, input logic [27:0] v, input string nm);
        q.push_back('{cyc, sel, v, nm});
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W = 1'b1;
        step();
        W = 1'b0;
    endtask

    initial begin
        logic [15:0] cnt_e;
        logic        exp_e;
        // Reset state
        step();
        ADDR = 16'h4003;
        chk(0, 28'h0, "rst_din_tcount");
        chk(1, 28'h0, "rst_ledr");
        chk(2, 28'h0, "rst_texp");
        step();
        ADDR = 16'h5000;
        chk(0, 28'h0, "rst_din_unmapped");
        step();
        Resetn = 1'b1;
        step();
        // LED write and read-back
        wr(16'h1000, 16'hFFFF);
        chk(1, 28'h3FF, "ledr_write");
        chk(0, 28'h03FF, "ledr_readback");
        step();
        // RAM write strobe and read path
        ADDR = 16'h0123; DOUT = 16'h1234; W = 1'b1;
        chk(3, 28'h1, "mem_we_region0");
        chk(4, 28'h123, "mem_addr");
        step();
        W = 1'b0; ADDR = 16'h0005; mem_q = 16'hBEEF;
        chk(3, 28'h0, "mem_we_idle");
        chk(0, 28'hBEEF, "ram_read");
        step();
        // Unmapped and SW-region writes are ignored
        ADDR = 16'h5000; DOUT = 16'h0000; W = 1'b1;
        chk(3, 28'h0, "mem_we_unmapped");
        chk(0, 28'h0, "din_unmapped");
        step();
        ADDR = 16'h3000; W = 1'b1;
        chk(3, 28'h0, "mem_we_sw_region");
        step();
        W = 1'b0;
        chk(1, 28'h3FF, "ledr_unchanged");
        // SW synchronizer latency
        SW = 10'h2A5;
        chk(0, 28'h0, "sw_cycle0");
        step();
        chk(0, 28'h0, "sw_after_edge1");
        step();
        chk(0, 28'h02A5, "sw_after_edge2");
        step();
        // HEX register
        wr(16'h2000, 16'h0A80);
        ADDR = 16'h2000;
`ifdef HEX_DECODE_EN
        chk(5, {7'b1000000, 7'b0001000, 7'b0000000, 7'b1000000}, "hex_decoded");
`else
        chk(5, 28'hFFF0A80, "hex_raw");
`endif
        chk(0, 28'h0A80, "hex_readback");
        step();
        // One-shot timer: TLOAD=3, EN
        wr(16'h4000, 16'h0003);
        wr(16'h4001, 16'h0001);
        ADDR = 16'h4003;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk(0, 28'(3 - k), "oneshot_tcount");
                chk(2, (k == 3) ? 28'h1 : 28'h0, "oneshot_texp");
                step();
            end
        end
        for (int j = 0; j < 4; j++) begin
            chk(0, 28'h0, "oneshot_hold");
            chk(2, 28'h1, "oneshot_texp_sticky");
            step();
        end
        ADDR = 16'h4002;
        chk(0, 28'h1, "tstat_read");
        step();
        wr(16'h4002, 16'h0001);
        chk(2, 28'h0, "w1c_clear");
        // Auto-reload timer: TLOAD=2, EN|AUTO
        wr(16'h4001, 16'h0000);
        wr(16'h4000, 16'h0002);
        wr(16'h4001, 16'h0003);
        for (int d = 0; d < 22; d++) begin
            W    = (d == 2 || d == 8 || d == 9 || d == 19 || d == 20);
            ADDR = (d == 8 || d == 9 || d == 19 || d == 20) ? 16'h4002 : 16'h4003;
            DOUT = (d == 2) ? 16'hFFFF : (d == 8) ? 16'h0000 : 16'h0001;
            cnt_e = d < 4 ? 16'd2 : d < 8 ? 16'd1 : d < 12 ? 16'd0 :
                    d < 16 ? 16'd2 : d < 20 ? 16'd1 : 16'd0;
            exp_e = (d == 8 || d == 9 || d == 20);
            chk(0, (ADDR == 16'h4002) ? 28'(exp_e) : 28'(cnt_e), "auto_din");
            chk(2, 28'(exp_e), "auto_texp");
            step();
        end
        W = 1'b0;
        ADDR = 16'h4001;
        chk(0, 28'h3, "tctrl_read");
        step();
        ADDR = 16'h4000;
        chk(0, 28'h2, "tload_read");
        step();
        // Mid-run asynchronous reset
        ADDR = 16'h4003;
        Resetn = 1'b0;
        #1;
        chk(1, 28'h0, "midrst_ledr");
        chk(0, 28'h0, "midrst_tcount");
        step();
        ADDR = 16'h3000;
        chk(0, 28'h0, "midrst_sw_sync");
        step();
        ADDR = 16'h2000;
        chk(0, 28'h0, "midrst_hex");
        step();
        Resetn = 1'b1;
        ADDR = 16'h3000;
        step();
        step();
        chk(0, 28'h02A5, "post_rst_sw");
        step();
        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
